// File: rtl/sentinel_auth_fsm.sv
// Access-verification sequencer: captures a presented code, checks it against a
// fixed key and drives timed grant/deny/lockout indications with failure counting.
module sentinel_auth_fsm #(
  parameter int                   KEY_WIDTH      = 8,
  parameter logic [KEY_WIDTH-1:0] KEY_VALUE      = 8'hA5,
  parameter int                   MAX_ATTEMPTS   = 3,
  parameter int                   GRANT_CYCLES   = 16,
  parameter int                   LOCKOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic [KEY_WIDTH-1:0] code_in,
  input  logic                 code_valid,
  input  logic                 clear,
  output logic                 granted,
  output logic                 denied,
  output logic                 locked,
  output logic                 busy,
  output logic [2:0]           fail_count,
  output logic [2:0]           state
);

  localparam int MAX_CYC = (GRANT_CYCLES > LOCKOUT_CYCLES) ? GRANT_CYCLES : LOCKOUT_CYCLES;
  localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [TW-1:0] GRANT_LOAD = TW'(GRANT_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LOAD  = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [3:0]    MAX_A      = 4'(MAX_ATTEMPTS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CHECK   = 3'd1,
    S_GRANTED = 3'd2,
    S_DENIED  = 3'd3,
    S_LOCKOUT = 3'd4
  } state_t;

  state_t               r_state;
  logic [KEY_WIDTH-1:0] r_capture;
  logic [TW-1:0]        r_timer;
  logic [2:0]           r_fail_count;
  logic                 r_granted;
  logic                 r_denied;
  logic                 r_locked;
  logic                 r_busy;
  logic                 w_last_attempt;

  assign w_last_attempt = (({1'b0, r_fail_count} + 4'd1) == MAX_A);

  // Indications are registered alongside each state change so outputs never see inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_capture    <= '0;
      r_timer      <= '0;
      r_fail_count <= '0;
      r_granted    <= 1'b0;
      r_denied     <= 1'b0;
      r_locked     <= 1'b0;
      r_busy       <= 1'b0;
    end else if (ena) begin
      case (r_state)
        S_IDLE: begin
          if (clear) begin
            r_fail_count <= '0;
          end else if (code_valid) begin
            r_capture <= code_in;
            r_state   <= S_CHECK;
            r_busy    <= 1'b1;
          end
        end
        S_CHECK: begin
          if (r_capture == KEY_VALUE) begin
            r_fail_count <= '0;
            r_timer      <= GRANT_LOAD;
            r_state      <= S_GRANTED;
            r_granted    <= 1'b1;
          end else if (w_last_attempt) begin
            r_fail_count <= r_fail_count + 3'd1;
            r_timer      <= LOCK_LOAD;
            r_state      <= S_LOCKOUT;
            r_locked     <= 1'b1;
          end else begin
            r_fail_count <= r_fail_count + 3'd1;
            r_timer      <= GRANT_LOAD;
            r_state      <= S_DENIED;
            r_denied     <= 1'b1;
          end
        end
        S_GRANTED, S_DENIED, S_LOCKOUT: begin
          // Timer is loaded with count-1, so zero marks the last indication cycle.
          if (r_timer == '0) begin
            r_state   <= S_IDLE;
            r_granted <= 1'b0;
            r_denied  <= 1'b0;
            r_locked  <= 1'b0;
            r_busy    <= 1'b0;
            if (r_state == S_LOCKOUT) begin
              r_fail_count <= '0;
            end
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_granted <= 1'b0;
          r_denied  <= 1'b0;
          r_locked  <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign granted    = r_granted;
  assign denied     = r_denied;
  assign locked     = r_locked;
  assign busy       = r_busy;
  assign fail_count = r_fail_count;
  assign state      = r_state;

endmodule
